// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Decides whether the CPU or the FPU owns the shared data memory and drives
//   the bus mux select. Every ownership change passes through a one-cycle
//   TURN state, so the mux never switches while a grant is live. Simultaneous
//   requests from IDLE are resolved round-robin. A tenure limit revokes an
//   owner that holds the bus for too long while the other master is waiting.
//
// Ports
//   clk          single clock, shared with both masters
//   rst_n        asynchronous active-low reset
//   cpu_req      CPU level request, held for as long as it needs the bus
//   fpu_req      FPU level request
//   cpu_gnt      CPU may drive memory this cycle (registered)
//   fpu_gnt      FPU may drive memory this cycle (registered)
//   bus_control  mux select, 0 = CPU, 1 = FPU (registered)
//   bus_busy     cpu_gnt | fpu_gnt (registered)
//   preempt      one-cycle pulse in the TURN cycle that follows a revocation
module memory_bus_arbiter #(
  parameter int MAX_TENURE = 16,
  parameter int TENURE_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic fpu_req,
  output logic cpu_gnt,
  output logic fpu_gnt,
  output logic bus_control,
  output logic bus_busy,
  output logic preempt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_OWN = 2'd1,
    ST_FPU_OWN = 2'd2,
    ST_TURN    = 2'd3
  } state_t;

  // A zero limit turns preemption off entirely.
  localparam bit                PREEMPT_EN  = (MAX_TENURE != 0);
  localparam logic [TENURE_W-1:0] TENURE_LAST = TENURE_W'(MAX_TENURE - 1);
  localparam logic [TENURE_W-1:0] TENURE_SAT  = {TENURE_W{1'b1}};

  state_t              state_r;
  state_t              next_state_s;
  logic                target_r;
  logic                target_s;
  logic                last_owner_r;
  logic                winner_s;
  logic                preempt_s;
  logic [TENURE_W-1:0] tenure_r;
  logic                cpu_gnt_r;
  logic                fpu_gnt_r;
  logic                bus_control_r;
  logic                bus_busy_r;
  logic                preempt_r;
  logic                cpu_gnt_s;
  logic                fpu_gnt_s;
  logic                bus_control_s;
  logic                bus_busy_s;

  assign cpu_gnt     = cpu_gnt_r;
  assign fpu_gnt     = fpu_gnt_r;
  assign bus_control = bus_control_r;
  assign bus_busy    = bus_busy_r;
  assign preempt     = preempt_r;

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      target_r      <= 1'b0;
      last_owner_r  <= 1'b1;  // FPU, so the CPU wins the first tie
      tenure_r      <= '0;
      cpu_gnt_r     <= 1'b0;
      fpu_gnt_r     <= 1'b0;
      bus_control_r <= 1'b0;
      bus_busy_r    <= 1'b0;
      preempt_r     <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      target_r      <= target_s;
      cpu_gnt_r     <= cpu_gnt_s;
      fpu_gnt_r     <= fpu_gnt_s;
      bus_control_r <= bus_control_s;
      bus_busy_r    <= bus_busy_s;
      preempt_r     <= preempt_s;
      if (next_state_s == ST_CPU_OWN) begin
        last_owner_r <= 1'b0;
      end else if (next_state_s == ST_FPU_OWN) begin
        last_owner_r <= 1'b1;
      end else begin
        last_owner_r <= last_owner_r;
      end
      // Clear on entry to an OWN state, count while staying, never wrap.
      if ((next_state_s == ST_CPU_OWN || next_state_s == ST_FPU_OWN) &&
          (state_r != next_state_s)) begin
        tenure_r <= '0;
      end else if ((state_r == ST_CPU_OWN || state_r == ST_FPU_OWN) &&
                   (tenure_r != TENURE_SAT)) begin
        tenure_r <= tenure_r + TENURE_W'(1);
      end else begin
        tenure_r <= tenure_r;
      end
    end
  end

  // Next-state decision, TURN target and revocation detection.
  always_comb begin
    next_state_s = state_r;
    target_s     = target_r;
    preempt_s    = 1'b0;
    winner_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req && fpu_req) begin
          winner_s = ~last_owner_r;
        end else if (fpu_req) begin
          winner_s = 1'b1;
        end else begin
          winner_s = 1'b0;
        end
        // Grant directly only when the mux is already parked on the winner.
        if (cpu_req || fpu_req) begin
          if (winner_s == bus_control_r) begin
            next_state_s = winner_s ? ST_FPU_OWN : ST_CPU_OWN;
          end else begin
            next_state_s = ST_TURN;
            target_s     = winner_s;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CPU_OWN: begin
        if (!cpu_req) begin
          if (fpu_req) begin
            next_state_s = ST_TURN;
            target_s     = 1'b1;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else if (fpu_req && PREEMPT_EN && (tenure_r == TENURE_LAST)) begin
          next_state_s = ST_TURN;
          target_s     = 1'b1;
          preempt_s    = 1'b1;
        end else begin
          next_state_s = ST_CPU_OWN;
        end
      end
      ST_FPU_OWN: begin
        if (!fpu_req) begin
          if (cpu_req) begin
            next_state_s = ST_TURN;
            target_s     = 1'b0;
          end else begin
            next_state_s = ST_IDLE;
          end
        end else if (cpu_req && PREEMPT_EN && (tenure_r == TENURE_LAST)) begin
          next_state_s = ST_TURN;
          target_s     = 1'b0;
          preempt_s    = 1'b1;
        end else begin
          next_state_s = ST_FPU_OWN;
        end
      end
      ST_TURN: begin
        if (target_r ? fpu_req : cpu_req) begin
          next_state_s = target_r ? ST_FPU_OWN : ST_CPU_OWN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    cpu_gnt_s = (next_state_s == ST_CPU_OWN);
    fpu_gnt_s = (next_state_s == ST_FPU_OWN);
    bus_busy_s = cpu_gnt_s | fpu_gnt_s;
    // The mux only moves on entry to TURN, when no grant can be live.
    if (next_state_s == ST_TURN) begin
      bus_control_s = target_s;
    end else begin
      bus_control_s = bus_control_r;
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

  localparam int MAXT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_req;
  logic fpu_req;
  logic cpu_gnt;
  logic fpu_gnt;
  logic bus_control;
  logic bus_busy;
  logic preempt;

  int checks = 0;
  int failures = 0;

  // Reference model: who holds the bus, whether a handover is in flight,
  // where the mux points, who was granted last, how long the owner has held.
  int m_own;   // -1 none, 0 CPU, 1 FPU
  bit m_turn;
  int m_dest;
  bit m_mux;
  int m_last;
  int m_held;
  bit m_pre;

  memory_bus_arbiter #(.MAX_TENURE(MAXT), .TENURE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .fpu_req(fpu_req),
    .cpu_gnt(cpu_gnt), .fpu_gnt(fpu_gnt), .bus_control(bus_control),
    .bus_busy(bus_busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_own = -1; m_turn = 1'b0; m_dest = 0; m_mux = 1'b0;
    m_last = 1; m_held = 0; m_pre = 1'b0;
  endtask

  function automatic logic [4:0] obs();
    return {cpu_gnt, fpu_gnt, bus_control, bus_busy, preempt};
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_own == 0, m_own == 1, m_mux, m_own != -1, m_pre};
  endfunction

  // Advance one clock; the model consumes the request levels seen at the edge.
  task automatic step();
    bit r[2];
    int w;
    @(posedge clk);
    r[0] = cpu_req; r[1] = fpu_req;
    m_pre = 1'b0;
    if (m_turn) begin
      m_turn = 1'b0;
      if (r[m_dest]) begin m_own = m_dest; m_last = m_dest; m_held = 0; end
      else m_own = -1;
    end else if (m_own == -1) begin
      if (r[0] || r[1]) begin
        w = (r[0] && r[1]) ? 1 - m_last : (r[1] ? 1 : 0);
        if (w == int'(m_mux)) begin m_own = w; m_last = w; m_held = 0; end
        else begin m_turn = 1'b1; m_dest = w; m_mux = w[0]; end
      end
    end else begin
      m_held++;
      if (!r[m_own]) begin
        if (r[1 - m_own]) begin
          m_turn = 1'b1; m_dest = 1 - m_own; m_mux = m_dest[0];
        end
        m_own = -1;
      end else if (r[1 - m_own] && m_held == MAXT) begin
        m_turn = 1'b1; m_dest = 1 - m_own; m_mux = m_dest[0]; m_pre = 1'b1;
        m_own = -1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req = 1'b0; fpu_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs(), 5'b00000);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_park_cpu();
    step();
    cpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); checks++;
      if (obs() !== exp_vec()) begin
        failures++; $display("FAIL park_cpu cyc=%0d got=%b exp=%b", i, obs(), exp_vec());
      end
    end
    checks++;
    if (cpu_gnt !== 1'b1 || bus_control !== 1'b0) begin
      failures++; $display("FAIL park_cpu_gnt got=%b%b exp=10", cpu_gnt, bus_control);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); checks++;
      if (obs() !== exp_vec()) begin
        failures++; $display("FAIL park_cpu_rel cyc=%0d got=%b exp=%b", i, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_handover_fpu();
    fpu_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); checks++;
      if (obs() !== exp_vec()) begin
        failures++; $display("FAIL handover cyc=%0d got=%b exp=%b", i, obs(), exp_vec());
      end
    end
    fpu_req = 1'b0;
    step(); step();
  endtask

  task automatic test_round_robin();
    logic [1:0] first_gnt[2];
    for (int k = 0; k < 2; k++) begin
      cpu_req = 1'b1; fpu_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step(); checks++;
        if (obs() !== exp_vec()) begin
          failures++; $display("FAIL round_robin k=%0d cyc=%0d got=%b exp=%b", k, i, obs(), exp_vec());
        end
      end
      first_gnt[k] = {cpu_gnt, fpu_gnt};
      cpu_req = 1'b0; fpu_req = 1'b0;
      step(); step(); step();
    end
    checks++;
    if (first_gnt[0] !== 2'b10 || first_gnt[1] !== 2'b01) begin
      failures++; $display("FAIL rr_order got=%b,%b exp=10,01", first_gnt[0], first_gnt[1]);
    end
  endtask

  task automatic test_preempt();
    int pulses = 0;
    cpu_req = 1'b1; fpu_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(); checks++;
      if (obs() !== exp_vec()) begin
        failures++; $display("FAIL preempt cyc=%0d got=%b exp=%b", i, obs(), exp_vec());
      end
      if (preempt === 1'b1) pulses++;
    end
    // A full cycle of tenure plus dead cycle is MAXT+1 clocks.
    checks++;
    if (pulses < 32 / (MAXT + 1) - 1) begin
      failures++; $display("FAIL preempt_count got=%0d exp>=%0d", pulses, 32 / (MAXT + 1) - 1);
    end
    cpu_req = 1'b0; fpu_req = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_turn_abort();
    // Park on CPU first so an FPU request needs a TURN.
    cpu_req = 1'b1; step(); step(); step(); cpu_req = 1'b0; step(); step();
    fpu_req = 1'b1; step(); fpu_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) cpu_req = 1'b1;
      step(); checks++;
      if (obs() !== exp_vec()) begin
        failures++; $display("FAIL turn_abort cyc=%0d got=%b exp=%b", i, obs(), exp_vec());
      end
    end
    cpu_req = 1'b0; step(); step();
  endtask

  task automatic test_reset_mid_grant();
    fpu_req = 1'b1;
    repeat (4) step();
    checks++;
    if (fpu_gnt !== 1'b1) begin
      failures++; $display("FAIL pre_reset_fpu_gnt got=%b exp=1", fpu_gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== 5'b00000) begin
      failures++; $display("FAIL async_reset got=%b exp=%b", obs(), 5'b00000);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); checks++;
      if (obs() !== exp_vec()) begin
        failures++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, obs(), exp_vec());
      end
    end
    fpu_req = 1'b0; step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(0, 3) == 0) fpu_req = ~fpu_req;
      step(); checks++;
      if (obs() !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d req=%b%b got=%b exp=%b", i, cpu_req, fpu_req, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_park_cpu();
    test_handover_fpu();
    test_round_robin();
    test_preempt();
    test_turn_abort();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Arbiter that drives `bus_control` into the shared memory bus mux and decides whether the CPU or the FPU owns the data memory. Each master runs a level request / grant handshake with it. Ownership changes always pass through a one-cycle turnaround so memory never sees a mid-cycle master switch. Round-robin resolves simultaneous requests, and a tenure limit keeps either master from starving the other.

## Interface
Parameters:
- `MAX_TENURE`, default 16: maximum granted cycles while the other master is waiting; 0 disables preemption.
- `TENURE_W`, default 5: counter width; must satisfy 2^TENURE_W > MAX_TENURE.

Ports:
- `clk`  in  1  single clock; also fed to both masters, so memory is clocked by `clk` regardless of owner.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  CPU requests the bus (level); held until done with the bus.
- `fpu_req`  in  1  FPU requests the bus (level).
- `cpu_gnt`  out  1  CPU may drive memory this cycle (registered).
- `fpu_gnt`  out  1  FPU may drive memory this cycle (registered).
- `bus_control`  out  1  mux select: 0 = CPU, 1 = FPU (registered).
- `bus_busy`  out  1  `cpu_gnt | fpu_gnt`.
- `preempt`  out  1  one-cycle pulse when an owner is revoked by the tenure limit.

## Operation
- A master drives `mem_read`/`mem_write` nonzero only in cycles where its gnt is 1. Otherwise it drives 0. The master enforces this, not the arbiter.
- States: IDLE, CPU_OWN, FPU_OWN, TURN.
- Register `last_owner` holds the most recently granted master. Reset value = FPU, so the CPU wins the first tie.
- Register `target` holds the master the bus is moving to in TURN.

IDLE:
- No request: stay in IDLE. `bus_control` holds its value (parked).
- Exactly one request, and that master equals `bus_control`: go to its OWN state.
- Exactly one request, and it differs from `bus_control`: go to TURN with `target` = requester.
- Both request: winner = not `last_owner`. Apply the same park rule as for a single request.

CPU_OWN (FPU_OWN is symmetric):
- `cpu_gnt` = 1. The tenure counter increments every cycle in this state and clears on entry.
- `cpu_req` = 0 and `fpu_req` = 1: go to TURN, `target` = FPU.
- `cpu_req` = 0 and `fpu_req` = 0: go to IDLE.
- `cpu_req` = 1, `fpu_req` = 1, `MAX_TENURE` != 0 and counter == `MAX_TENURE`-1: go to TURN, `target` = FPU, and pulse `preempt`. The revoked CPU keeps `cpu_req` high and is re-granted later.
- Otherwise stay in CPU_OWN.

TURN:
- Both gnts are 0. `bus_control` = `target`; it was updated at the edge entering TURN.
- `target` request still high: go to `target` OWN.
- `target` request dropped: go to IDLE.

Other rules:
- `last_owner` updates on entry to any OWN state.
- The counter saturates and never wraps.

## Timing
Reset values (asynchronous on `rst_n` low, effective immediately):
- State = IDLE; `cpu_gnt` = `fpu_gnt` = 0; `bus_control` = 0; `bus_busy` = 0; `preempt` = 0; counter = 0; `last_owner` = FPU.
- Reset asserted mid-grant drops the gnt the same cycle. Release is synchronous to the next `clk` edge.

Latency and handover:
- Request to grant, bus parked on the requester: req seen high at edge N → gnt = 1 after edge N (1 cycle).
- Request to grant, bus parked on the other master: `bus_control` flips after edge N, gnt rises after edge N+1 (2 cycles).
- Release with handover: owner req low at edge N → owner gnt = 0 and `bus_control` flips after edge N → new gnt = 1 after edge N+1. There is exactly one dead cycle.
- Owner gnt drops in the cycle after its req falls. The master must not issue an access in the cycle it drops req.
- `bus_control` changes only on entry to TURN, never while any gnt = 1.
- `preempt` is high only for the TURN cycle that follows the revocation.
- Grant tenure under contention is exactly `MAX_TENURE` cycles.

## Test plan
- Reset, then `cpu_req` = 1 at cycle 2 → `cpu_gnt` = 1 from cycle 3, `bus_control` stays 0. Drop `cpu_req` → `cpu_gnt` = 0 next cycle, state IDLE.
- Bus parked on CPU, `fpu_req` = 1 at cycle 10 → `bus_control` = 1 at cycle 11 with both gnts 0, `fpu_gnt` = 1 at cycle 12.
- Both requests rise together after reset → CPU granted first. Both rise together again later → FPU granted (round-robin).
- `MAX_TENURE` = 4: CPU owns with both requests held → `cpu_gnt` high exactly 4 cycles, `preempt` pulses once, one dead cycle, `fpu_gnt` high 4 cycles, then back to CPU. Repeats indefinitely.
- In TURN toward FPU, `fpu_req` dropped → IDLE with `bus_control` = 1 and no gnt. A later `cpu_req` → TURN back to 0, then `cpu_gnt`.
- `rst_n` pulsed low while `fpu_gnt` = 1 → all outputs 0 immediately. After release with `fpu_req` still high → TURN, then `fpu_gnt` after 2 cycles.
